dice_tid_dispatcher: RTL and testbench

DICE_TID_DISPATCHER -- requirements
Module: dice_tid_dispatcher

---
 rtl/dice_tid_dispatcher.sv | 158 +++++++++++++++
 tb/tb_dice_tid_dispatcher.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_tid_dispatcher.sv
// Thread-ID dispatcher: latches a CTA launch, validates its size, then issues
// one thread coordinate beat per accepted handshake in x-fastest order.
module dice_tid_dispatcher #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_TID      = 512,
  parameter int TID_WIDTH    = $clog2(NUM_TID),
  parameter int CTA_ID_WIDTH = $clog2(65535)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    launch_valid,
  output logic                    launch_ready,
  input  logic [TID_WIDTH-1:0]    cfg_ntid_x,
  input  logic [TID_WIDTH-1:0]    cfg_ntid_y,
  input  logic [TID_WIDTH-1:0]    cfg_ntid_z,
  input  logic [CTA_ID_WIDTH-1:0] cfg_ctaid_x,
  input  logic [CTA_ID_WIDTH-1:0] cfg_ctaid_y,
  input  logic [CTA_ID_WIDTH-1:0] cfg_ctaid_z,
  input  logic [CTA_ID_WIDTH-1:0] cfg_nctaid_x,
  input  logic [CTA_ID_WIDTH-1:0] cfg_nctaid_y,
  input  logic [CTA_ID_WIDTH-1:0] cfg_nctaid_z,
  output logic                    thr_valid,
  input  logic                    thr_ready,
  output logic [TID_WIDTH-1:0]    tid_x,
  output logic [TID_WIDTH-1:0]    tid_y,
  output logic [TID_WIDTH-1:0]    tid_z,
  output logic [TID_WIDTH-1:0]    ntid_x,
  output logic [TID_WIDTH-1:0]    ntid_y,
  output logic [TID_WIDTH-1:0]    ntid_z,
  output logic [CTA_ID_WIDTH-1:0] ctaid_x,
  output logic [CTA_ID_WIDTH-1:0] ctaid_y,
  output logic [CTA_ID_WIDTH-1:0] ctaid_z,
  output logic [CTA_ID_WIDTH-1:0] nctaid_x,
  output logic [CTA_ID_WIDTH-1:0] nctaid_y,
  output logic [CTA_ID_WIDTH-1:0] nctaid_z,
  output logic [TID_WIDTH-1:0]    tid_lin,
  output logic                    thr_last,
  output logic                    done,
  output logic                    err
);

  localparam int TOT_W = 3 * TID_WIDTH;
  localparam logic [TID_WIDTH-1:0] TID_ONE = 1;

  // The linear thread index is meant to be carried on a datapath word.
  if (DATA_WIDTH < TID_WIDTH) begin : g_width_guard
    $error("dice_tid_dispatcher: DATA_WIDTH narrower than TID_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DONE} state_t;

  state_t state, state_n;

  logic [TOT_W-1:0] total;
  logic             over;
  logic             fire;
  logic             x_end, y_end, z_end;

  // Full-width product so an oversized CTA can never alias to a legal size.
  assign total = TOT_W'(ntid_x) * TOT_W'(ntid_y) * TOT_W'(ntid_z);
  assign over  = total > TOT_W'(NUM_TID);

  assign launch_ready = (state == IDLE);
  assign thr_valid    = (state == ISSUE);
  assign done         = (state == DONE);
  assign x_end        = (tid_x == ntid_x - TID_ONE);
  assign y_end        = (tid_y == ntid_y - TID_ONE);
  assign z_end        = (tid_z == ntid_z - TID_ONE);
  assign thr_last     = thr_valid && x_end && y_end && z_end;
  assign fire         = thr_valid && thr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (launch_valid) state_n = CHECK;
      CHECK: begin
        if (total == '0) state_n = DONE;
        else if (over)   state_n = IDLE;
        else             state_n = ISSUE;
      end
      ISSUE: if (fire && thr_last) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clr) state_n = IDLE;
  end

  // Counters return to zero after the final beat so idle outputs read clean.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tid_x    <= '0;
      tid_y    <= '0;
      tid_z    <= '0;
      tid_lin  <= '0;
      ntid_x   <= '0;
      ntid_y   <= '0;
      ntid_z   <= '0;
      ctaid_x  <= '0;
      ctaid_y  <= '0;
      ctaid_z  <= '0;
      nctaid_x <= '0;
      nctaid_y <= '0;
      nctaid_z <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clr) begin
        tid_x   <= '0;
        tid_y   <= '0;
        tid_z   <= '0;
        tid_lin <= '0;
      end else if (state == IDLE && launch_valid) begin
        ntid_x   <= cfg_ntid_x;
        ntid_y   <= cfg_ntid_y;
        ntid_z   <= cfg_ntid_z;
        ctaid_x  <= cfg_ctaid_x;
        ctaid_y  <= cfg_ctaid_y;
        ctaid_z  <= cfg_ctaid_z;
        nctaid_x <= cfg_nctaid_x;
        nctaid_y <= cfg_nctaid_y;
        nctaid_z <= cfg_nctaid_z;
      end else if (state == CHECK) begin
        tid_x   <= '0;
        tid_y   <= '0;
        tid_z   <= '0;
        tid_lin <= '0;
        err     <= over;
      end else if (fire) begin
        if (thr_last) begin
          tid_x   <= '0;
          tid_y   <= '0;
          tid_z   <= '0;
          tid_lin <= '0;
        end else begin
          tid_lin <= tid_lin + TID_ONE;
          if (x_end) begin
            tid_x <= '0;
            if (y_end) begin
              tid_y <= '0;
              tid_z <= tid_z + TID_ONE;
            end else begin
              tid_y <= tid_y + TID_ONE;
            end
          end else begin
            tid_x <= tid_x + TID_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dice_tid_dispatcher.sv
// Self-checking bench for dice_tid_dispatcher: directed scenarios plus random
// launches compared against a nested-loop model of the thread enumeration.
module tb_dice_tid_dispatcher;

  localparam int NUM_TID = 512;
  localparam int TW      = 9;
  localparam int CW      = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          launch_valid = 1'b0;
  logic          launch_ready;
  logic [TW-1:0] cfg_ntid_x = '0, cfg_ntid_y = '0, cfg_ntid_z = '0;
  logic [CW-1:0] cfg_ctaid_x = '0, cfg_ctaid_y = '0, cfg_ctaid_z = '0;
  logic [CW-1:0] cfg_nctaid_x = '0, cfg_nctaid_y = '0, cfg_nctaid_z = '0;
  logic          thr_valid;
  logic          thr_ready = 1'b0;
  logic [TW-1:0] tid_x, tid_y, tid_z, ntid_x, ntid_y, ntid_z, tid_lin;
  logic [CW-1:0] ctaid_x, ctaid_y, ctaid_z, nctaid_x, nctaid_y, nctaid_z;
  logic          thr_last, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_x[$], exp_y[$], exp_z[$], exp_lin[$], exp_last[$];
  int obs_x[$], obs_y[$], obs_z[$], obs_lin[$], obs_last[$];
  int done_cnt, err_cnt, stall_bad, valid_cnt, last_cyc, done_cyc, ready_after;
  bit timed_out;

  dice_tid_dispatcher #(
    .DATA_WIDTH(32), .NUM_TID(NUM_TID), .TID_WIDTH(TW), .CTA_ID_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .launch_valid(launch_valid), .launch_ready(launch_ready),
    .cfg_ntid_x(cfg_ntid_x), .cfg_ntid_y(cfg_ntid_y), .cfg_ntid_z(cfg_ntid_z),
    .cfg_ctaid_x(cfg_ctaid_x), .cfg_ctaid_y(cfg_ctaid_y), .cfg_ctaid_z(cfg_ctaid_z),
    .cfg_nctaid_x(cfg_nctaid_x), .cfg_nctaid_y(cfg_nctaid_y), .cfg_nctaid_z(cfg_nctaid_z),
    .thr_valid(thr_valid), .thr_ready(thr_ready),
    .tid_x(tid_x), .tid_y(tid_y), .tid_z(tid_z),
    .ntid_x(ntid_x), .ntid_y(ntid_y), .ntid_z(ntid_z),
    .ctaid_x(ctaid_x), .ctaid_y(ctaid_y), .ctaid_z(ctaid_z),
    .nctaid_x(nctaid_x), .nctaid_y(nctaid_y), .nctaid_z(nctaid_z),
    .tid_lin(tid_lin), .thr_last(thr_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: the threads of an x*y*z CTA in x-fastest order.
  function automatic void build_expected(input int x, input int y, input int z);
    int lin;
    lin = 0;
    exp_x.delete(); exp_y.delete(); exp_z.delete(); exp_lin.delete(); exp_last.delete();
    for (int k = 0; k < z; k++)
      for (int j = 0; j < y; j++)
        for (int i = 0; i < x; i++) begin
          exp_x.push_back(i);
          exp_y.push_back(j);
          exp_z.push_back(k);
          exp_lin.push_back(lin);
          exp_last.push_back(int'(lin == x * y * z - 1));
          lin++;
        end
  endfunction

  task automatic do_launch(input int x, input int y, input int z,
                           input int cx, input int cy, input int cz,
                           input int nx, input int ny, input int nz);
    int w;
    w = 0;
    @(negedge clk);
    while (!launch_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!launch_ready) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL launch_wait: launch_ready=%0b required 1", launch_ready);
    end
    cfg_ntid_x = TW'(x);    cfg_ntid_y = TW'(y);    cfg_ntid_z = TW'(z);
    cfg_ctaid_x = CW'(cx);  cfg_ctaid_y = CW'(cy);  cfg_ctaid_z = CW'(cz);
    cfg_nctaid_x = CW'(nx); cfg_nctaid_y = CW'(ny); cfg_nctaid_z = CW'(nz);
    launch_valid = 1'b1;
    @(negedge clk);
    launch_valid = 1'b0;
  endtask

  // Observe one launch to completion; mode 0 ready=1, 1 toggling, 2 random.
  task automatic collect(input int mode);
    bit ended, prev_stall;
    int tail, px, py, pz, pl;
    ended = 0; prev_stall = 0; tail = 0; px = 0; py = 0; pz = 0; pl = 0;
    obs_x.delete(); obs_y.delete(); obs_z.delete(); obs_lin.delete(); obs_last.delete();
    done_cnt = 0; err_cnt = 0; stall_bad = 0; valid_cnt = 0;
    last_cyc = -1; done_cyc = -1; ready_after = 0; timed_out = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      case (mode)
        0:       thr_ready = 1'b1;
        1:       thr_ready = (cyc % 2 == 0);
        default: thr_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall && (!thr_valid || int'(tid_x) != px || int'(tid_y) != py ||
                         int'(tid_z) != pz || int'(tid_lin) != pl))
        stall_bad++;
      if (thr_valid) valid_cnt++;
      if (thr_valid && thr_ready) begin
        obs_x.push_back(int'(tid_x));
        obs_y.push_back(int'(tid_y));
        obs_z.push_back(int'(tid_z));
        obs_lin.push_back(int'(tid_lin));
        obs_last.push_back(int'(thr_last));
        if (thr_last) last_cyc = cyc;
      end
      prev_stall = thr_valid && !thr_ready;
      px = int'(tid_x); py = int'(tid_y); pz = int'(tid_z); pl = int'(tid_lin);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (err) err_cnt++;
      if (ended) begin
        tail++;
        if (tail == 1) ready_after = int'(launch_ready);
        if (tail == 2) begin
          timed_out = 0;
          break;
        end
      end else if (done || err) begin
        ended = 1;
      end
    end
    thr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (launch_ready !== 1'b1 || thr_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        thr_last !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: ready=%b valid=%b done=%b err=%b last=%b required 1,0,0,0,0",
               launch_ready, thr_valid, done, err, thr_last);
    end
    n_checks++;
    if (tid_x !== '0 || tid_y !== '0 || tid_z !== '0 || tid_lin !== '0 || ntid_x !== '0 ||
        ntid_y !== '0 || ntid_z !== '0 || ctaid_x !== '0 || nctaid_z !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: tid=%0d,%0d,%0d lin=%0d ntid_x=%0d ctaid_x=%0d required all 0",
               tid_x, tid_y, tid_z, tid_lin, ntid_x, ctaid_x);
    end
    clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    do_launch(2, 2, 1, 3, 4, 5, 6, 7, 8);
    n_checks++;
    if (launch_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_busy: launch_ready=%b required 0", launch_ready);
    end
    build_expected(2, 2, 1);
    collect(0);
    n_checks++;
    if (obs_x.size() != exp_x.size()) begin
      n_fail++;
      $display("[TB] FAIL basic_count: beats=%0d required %0d", obs_x.size(), exp_x.size());
    end
    n = (obs_x.size() < exp_x.size()) ? obs_x.size() : exp_x.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_z[i] != exp_z[i] ||
          obs_lin[i] != exp_lin[i] || obs_last[i] != exp_last[i]) begin
        n_fail++;
        $display("[TB] FAIL basic_beat%0d: got (%0d,%0d,%0d) lin=%0d last=%0d required (%0d,%0d,%0d) lin=%0d last=%0d",
                 i, obs_x[i], obs_y[i], obs_z[i], obs_lin[i], obs_last[i],
                 exp_x[i], exp_y[i], exp_z[i], exp_lin[i], exp_last[i]);
      end
    end
    n_checks++;
    if (timed_out || done_cnt != 1 || done_cyc != last_cyc + 1 || err_cnt != 0 ||
        ready_after != 1 || valid_cnt != 4) begin
      n_fail++;
      $display("[TB] FAIL basic_done: timeout=%0d done=%0d at %0d last at %0d err=%0d ready=%0d valid=%0d required 0,1,last+1,0,1,4",
               timed_out, done_cnt, done_cyc, last_cyc, err_cnt, ready_after, valid_cnt);
    end
    n_checks++;
    if (ctaid_x !== 16'd3 || ctaid_z !== 16'd5 || nctaid_y !== 16'd7) begin
      n_fail++;
      $display("[TB] FAIL basic_latch: ctaid_x=%0d ctaid_z=%0d nctaid_y=%0d required 3,5,7",
               ctaid_x, ctaid_z, nctaid_y);
    end
  endtask

  task automatic test_stall();
    int n;
    do_launch(3, 1, 2, 0, 0, 0, 1, 1, 1);
    build_expected(3, 1, 2);
    collect(1);
    n_checks++;
    if (obs_x.size() != 6 || stall_bad != 0 || timed_out || done_cnt != 1) begin
      n_fail++;
      $display("[TB] FAIL stall_summary: beats=%0d stall_changes=%0d timeout=%0d done=%0d required 6,0,0,1",
               obs_x.size(), stall_bad, timed_out, done_cnt);
    end
    n = (obs_x.size() < exp_x.size()) ? obs_x.size() : exp_x.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_z[i] != exp_z[i] ||
          obs_lin[i] != exp_lin[i] || obs_last[i] != exp_last[i]) begin
        n_fail++;
        $display("[TB] FAIL stall_beat%0d: got (%0d,%0d,%0d) lin=%0d last=%0d required (%0d,%0d,%0d) lin=%0d last=%0d",
                 i, obs_x[i], obs_y[i], obs_z[i], obs_lin[i], obs_last[i],
                 exp_x[i], exp_y[i], exp_z[i], exp_lin[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_zero();
    do_launch(0, 4, 4, 1, 1, 1, 2, 2, 2);
    collect(0);
    n_checks++;
    if (valid_cnt != 0 || done_cnt != 1 || done_cyc != 0 || err_cnt != 0 || timed_out ||
        ready_after != 1) begin
      n_fail++;
      $display("[TB] FAIL zero_dim: valid=%0d done=%0d at %0d err=%0d timeout=%0d ready=%0d required 0,1,0,0,0,1",
               valid_cnt, done_cnt, done_cyc, err_cnt, timed_out, ready_after);
    end
  endtask

  task automatic test_overflow();
    do_launch(16, 16, 4, 9, 9, 9, 9, 9, 9);
    collect(0);
    n_checks++;
    if (valid_cnt != 0 || err_cnt != 1 || done_cnt != 0 || timed_out || ready_after != 1) begin
      n_fail++;
      $display("[TB] FAIL overflow: valid=%0d err=%0d done=%0d timeout=%0d ready=%0d required 0,1,0,0,1",
               valid_cnt, err_cnt, done_cnt, timed_out, ready_after);
    end
  endtask

  task automatic test_clr();
    bit hit;
    int dn;
    hit = 0;
    dn = 0;
    do_launch(8, 1, 1, 0, 0, 0, 1, 1, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      thr_ready = 1'b1;
      if (thr_valid && tid_lin == 9'd2) begin
        clr = 1'b1;
        hit = 1;
        break;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("[TB] FAIL clr_reach: beat 3 seen=%0b required 1", hit);
    end
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (thr_valid !== 1'b0 || tid_x !== '0 || tid_lin !== '0 || done !== 1'b0 ||
        launch_ready !== 1'b1 || ntid_x !== 9'd8) begin
      n_fail++;
      $display("[TB] FAIL clr_abort: valid=%b tid_x=%0d lin=%0d done=%b ready=%b ntid_x=%0d required 0,0,0,0,1,8",
               thr_valid, tid_x, tid_lin, done, launch_ready, ntid_x);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || thr_valid) dn++;
    end
    n_checks++;
    if (dn != 0) begin
      n_fail++;
      $display("[TB] FAIL clr_quiet: done/valid cycles=%0d required 0", dn);
    end
    thr_ready = 1'b0;
    do_launch(8, 1, 1, 0, 0, 0, 1, 1, 1);
    collect(0);
    n_checks++;
    if (obs_x.size() != 8 || obs_x[0] != 0 || obs_lin[0] != 0 || done_cnt != 1) begin
      n_fail++;
      $display("[TB] FAIL clr_relaunch: beats=%0d first_x=%0d first_lin=%0d done=%0d required 8,0,0,1",
               obs_x.size(), (obs_x.size() > 0) ? obs_x[0] : -1,
               (obs_lin.size() > 0) ? obs_lin[0] : -1, done_cnt);
    end
  endtask

  task automatic test_ignore_launch();
    int bad_hold, n;
    bit got_done;
    bad_hold = 0;
    got_done = 0;
    do_launch(4, 2, 1, 5, 6, 7, 10, 11, 12);
    cfg_ntid_x = 9'd2; cfg_ntid_y = 9'd2; cfg_ntid_z = 9'd2;
    cfg_ctaid_x = 16'd1; cfg_ctaid_y = 16'd1; cfg_ctaid_z = 16'd1;
    cfg_nctaid_x = 16'd2; cfg_nctaid_y = 16'd2; cfg_nctaid_z = 16'd2;
    launch_valid = 1'b1;
    build_expected(4, 2, 1);
    obs_x.delete(); obs_y.delete(); obs_z.delete(); obs_lin.delete(); obs_last.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      thr_ready = 1'b1;
      if (thr_valid) begin
        if (ntid_x !== 9'd4 || ntid_y !== 9'd2 || ntid_z !== 9'd1 || ctaid_x !== 16'd5 ||
            nctaid_z !== 16'd12)
          bad_hold++;
        obs_x.push_back(int'(tid_x));
        obs_y.push_back(int'(tid_y));
        obs_z.push_back(int'(tid_z));
        obs_lin.push_back(int'(tid_lin));
        obs_last.push_back(int'(thr_last));
      end
      if (done) begin
        got_done = 1;
        launch_valid = 1'b0;
        break;
      end
    end
    launch_valid = 1'b0;
    thr_ready = 1'b0;
    n_checks++;
    if (!got_done || bad_hold != 0 || obs_x.size() != exp_x.size()) begin
      n_fail++;
      $display("[TB] FAIL ignore_hold: done=%0b hold_errors=%0d beats=%0d required 1,0,%0d",
               got_done, bad_hold, obs_x.size(), exp_x.size());
    end
    n = (obs_x.size() < exp_x.size()) ? obs_x.size() : exp_x.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_z[i] != exp_z[i] ||
          obs_lin[i] != exp_lin[i] || obs_last[i] != exp_last[i]) begin
        n_fail++;
        $display("[TB] FAIL ignore_beat%0d: got (%0d,%0d,%0d) lin=%0d required (%0d,%0d,%0d) lin=%0d",
                 i, obs_x[i], obs_y[i], obs_z[i], obs_lin[i], exp_x[i], exp_y[i], exp_z[i], exp_lin[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (launch_ready !== 1'b1 || ntid_x !== 9'd4 || ctaid_x !== 16'd5) begin
      n_fail++;
      $display("[TB] FAIL ignore_idle: ready=%b ntid_x=%0d ctaid_x=%0d required 1,4,5",
               launch_ready, ntid_x, ctaid_x);
    end
    do_launch(2, 2, 2, 1, 1, 1, 2, 2, 2);
    n_checks++;
    if (ntid_x !== 9'd2 || ntid_z !== 9'd2 || ctaid_x !== 16'd1 || nctaid_z !== 16'd2) begin
      n_fail++;
      $display("[TB] FAIL ignore_newlatch: ntid_x=%0d ntid_z=%0d ctaid_x=%0d nctaid_z=%0d required 2,2,1,2",
               ntid_x, ntid_z, ctaid_x, nctaid_z);
    end
    collect(0);
    n_checks++;
    if (obs_x.size() != 8 || done_cnt != 1) begin
      n_fail++;
      $display("[TB] FAIL ignore_newrun: beats=%0d done=%0d required 8,1", obs_x.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid_issue();
    bit hit;
    int dn;
    hit = 0;
    dn = 0;
    do_launch(4, 4, 1, 2, 2, 2, 3, 3, 3);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      thr_ready = 1'b1;
      if (thr_valid && tid_lin == 9'd3) begin
        rst_n = 1'b0;
        clr = 1'b1;
        hit = 1;
        break;
      end
    end
    @(negedge clk);
    n_checks++;
    if (!hit || thr_valid !== 1'b0 || launch_ready !== 1'b1 || done !== 1'b0 ||
        ntid_x !== '0 || tid_lin !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: reached=%0b valid=%b ready=%b done=%b ntid_x=%0d lin=%0d required 1,0,1,0,0,0",
               hit, thr_valid, launch_ready, done, ntid_x, tid_lin);
    end
    rst_n = 1'b1;
    clr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || thr_valid) dn++;
    end
    thr_ready = 1'b0;
    n_checks++;
    if (dn != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_quiet: done/valid cycles=%0d required 0", dn);
    end
  endtask

  task automatic test_random();
    int x, y, z, cx, tot, n;
    for (int it = 0; it < 16; it++) begin
      x = $urandom_range(0, 12);
      y = $urandom_range(0, 8);
      z = $urandom_range(0, 8);
      cx = $urandom_range(0, 65535);
      tot = x * y * z;
      do_launch(x, y, z, cx, it, 7, 100, 200, 300);
      if (tot > 0 && tot <= NUM_TID) build_expected(x, y, z);
      else begin
        exp_x.delete(); exp_y.delete(); exp_z.delete(); exp_lin.delete(); exp_last.delete();
      end
      collect(2);
      n_checks++;
      if (timed_out || obs_x.size() != exp_x.size() || stall_bad != 0 ||
          done_cnt != ((tot <= NUM_TID) ? 1 : 0) || err_cnt != ((tot > NUM_TID) ? 1 : 0) ||
          ready_after != 1) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_outcome (%0d,%0d,%0d): timeout=%0d beats=%0d stall=%0d done=%0d err=%0d ready=%0d required beats=%0d done=%0d err=%0d",
                 it, x, y, z, timed_out, obs_x.size(), stall_bad, done_cnt, err_cnt, ready_after,
                 exp_x.size(), (tot <= NUM_TID) ? 1 : 0, (tot > NUM_TID) ? 1 : 0);
      end
      n = (obs_x.size() < exp_x.size()) ? obs_x.size() : exp_x.size();
      n_checks++;
      for (int i = 0; i < n; i++) begin
        if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_z[i] != exp_z[i] ||
            obs_lin[i] != exp_lin[i] || obs_last[i] != exp_last[i]) begin
          n_fail++;
          $display("[TB] FAIL rand%0d_beat%0d: got (%0d,%0d,%0d) lin=%0d last=%0d required (%0d,%0d,%0d) lin=%0d last=%0d",
                   it, i, obs_x[i], obs_y[i], obs_z[i], obs_lin[i], obs_last[i],
                   exp_x[i], exp_y[i], exp_z[i], exp_lin[i], exp_last[i]);
          break;
        end
      end
      n_checks++;
      if (int'(ctaid_x) != cx || int'(ctaid_y) != it || int'(nctaid_z) != 300 ||
          int'(ntid_x) != x || int'(ntid_z) != z) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_latch: ctaid_x=%0d ctaid_y=%0d nctaid_z=%0d ntid=(%0d,%0d) required %0d,%0d,300,(%0d,%0d)",
                 it, ctaid_x, ctaid_y, nctaid_z, ntid_x, ntid_z, cx, it, x, z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_overflow();
    test_clr();
    test_ignore_launch();
    test_reset_mid_issue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
